ethernet_tx_scheduler: RTL and testbench

ETHERNET_TX_SCHEDULER -- requirements
Module: ethernet_tx_scheduler

---
 rtl/ethernet_pkg.sv | 20 ++
 rtl/round_robin_arbiter.sv | 20 ++
 rtl/ethernet_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_ethernet_tx_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ethernet_pkg;

   // Default inter-frame gap in scheduler clock cycles, and the largest legal payload.
   localparam int ETH_MIN_IFG     = 48;
   localparam int ETH_MAX_PAYLOAD = 1500;

   typedef enum logic [2:0] {
      IDLE,
      ARBITRATE,
      START,
      WAIT_DESC,
      STREAM,
      WAIT_IDLE,
      GAP
   } tx_state_e;

endpackage

// File: rtl/round_robin_arbiter.sv
// Two-way arbiter: the requester named by prio wins if it is requesting, else the other one.
// Latency: combinational.
// Backpressure: none; grant is all-zero when nobody requests.
// Ports: request (per-requester level), prio (index holding priority), grant (one-hot winner).
module round_robin_arbiter (
   input  logic [1:0] request,
   input  logic       prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (request[prio]) begin
         grant[prio] = 1'b1;
      end else if (request[~prio]) begin
         grant[~prio] = 1'b1;
      end
   end

endmodule

// File: rtl/ethernet_tx_scheduler.sv
// Shares one transmit MAC between two frame requesters with round-robin priority and an inter-frame gap.
// Latency: request to mac_transmit_o in 2 cycles (IDLE->ARBITRATE->START); payload bytes pass through combinationally.
// Backpressure: a byte pops only when the MAC reads and the granted source is valid; otherwise the stream stalls.
// Ports: request_i/dest_address_i/length_i/data_i/data_valid_i in from requesters; data_read_o/grant_o/done_o/reject_o
//        back to them; mac_* is the descriptor plus byte-stream handshake with the MAC.
module ethernet_tx_scheduler
   import ethernet_pkg::*;
#(
   parameter int IFG_CYCLES = ETH_MIN_IFG,
   parameter int MAX_LENGTH = ETH_MAX_PAYLOAD
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [1:0]       request_i,
   input  logic [1:0][47:0] dest_address_i,
   input  logic [1:0][15:0] length_i,
   input  logic [1:0][7:0]  data_i,
   input  logic [1:0]       data_valid_i,
   output logic [1:0]       data_read_o,
   output logic [1:0]       grant_o,
   output logic [1:0]       done_o,
   output logic [1:0]       reject_o,
   output logic             mac_transmit_o,
   output logic [47:0]      mac_dest_address_o,
   output logic [15:0]      mac_payload_length_o,
   input  logic             mac_read_descriptor_i,
   input  logic             mac_read_data_i,
   output logic             mac_data_ready_o,
   output logic [7:0]       mac_payload_data_o,
   input  logic             mac_tx_idle_i
);

   localparam logic [15:0] MAX_LEN  = 16'(MAX_LENGTH);
   // GAP is held while the counter runs 0..GAP_LAST, i.e. IFG_CYCLES cycles in total.
   localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

   tx_state_e   state_q, state_d;
   logic        prio_q, prio_d;
   logic        gidx_q, gidx_d;
   logic [1:0]  grant_q, grant_d;
   logic [47:0] dest_q, dest_d;
   logic [15:0] len_q, len_d;
   logic [15:0] remain_q, remain_d;
   logic [15:0] gap_q, gap_d;

   logic [1:0]  arb_grant;
   logic        win_idx;
   logic        len_bad;
   logic        pop;

   round_robin_arbiter u_arb (
      .request (request_i),
      .prio    (prio_q),
      .grant   (arb_grant)
   );

   assign win_idx = arb_grant[1];
   assign len_bad = (length_i[win_idx] == 16'd0) || (length_i[win_idx] > MAX_LEN);
   // A read strobe against an empty source is a stall: no pop, no count.
   assign pop     = (state_q == STREAM) && mac_read_data_i && data_valid_i[gidx_q];

   // Descriptor is shown to the MAC from the latched copy for the whole ownership window.
   assign grant_o              = grant_q;
   assign mac_dest_address_o   = (grant_q != 2'b00) ? dest_q : 48'd0;
   assign mac_payload_length_o = (grant_q != 2'b00) ? len_q  : 16'd0;

   always_comb begin
      state_d            = state_q;
      prio_d             = prio_q;
      gidx_d             = gidx_q;
      grant_d            = grant_q;
      dest_d             = dest_q;
      len_d              = len_q;
      remain_d           = remain_q;
      gap_d              = gap_q;
      reject_o           = 2'b00;
      done_o             = 2'b00;
      data_read_o        = 2'b00;
      mac_transmit_o     = 1'b0;
      mac_data_ready_o   = 1'b0;
      mac_payload_data_o = 8'd0;

      case (state_q)
         IDLE: begin
            if ((request_i != 2'b00) && mac_tx_idle_i) begin
               state_d = ARBITRATE;
            end
         end
         ARBITRATE: begin
            if (arb_grant == 2'b00) begin
               // Request withdrawn before it could be served.
               state_d = IDLE;
            end else if (len_bad) begin
               reject_o = arb_grant;
               prio_d   = ~win_idx;
               state_d  = IDLE;
            end else begin
               gidx_d   = win_idx;
               grant_d  = arb_grant;
               dest_d   = dest_address_i[win_idx];
               len_d    = length_i[win_idx];
               remain_d = length_i[win_idx];
               state_d  = START;
            end
         end
         START: begin
            mac_transmit_o = 1'b1;
            state_d        = WAIT_DESC;
         end
         WAIT_DESC: begin
            if (mac_read_descriptor_i) begin
               state_d = STREAM;
            end
         end
         STREAM: begin
            mac_payload_data_o  = data_i[gidx_q];
            mac_data_ready_o    = data_valid_i[gidx_q];
            data_read_o[gidx_q] = pop;
            if (pop) begin
               remain_d = remain_q - 16'd1;
               if (remain_q == 16'd1) begin
                  state_d = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (mac_tx_idle_i) begin
               done_o[gidx_q] = 1'b1;
               gap_d          = 16'd0;
               state_d        = GAP;
            end
         end
         GAP: begin
            if (gap_q >= GAP_LAST) begin
               grant_d = 2'b00;
               prio_d  = ~prio_q;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         gidx_q   <= 1'b0;
         grant_q  <= 2'b00;
         dest_q   <= 48'd0;
         len_q    <= 16'd0;
         remain_q <= 16'd0;
         gap_q    <= 16'd0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         gidx_q   <= gidx_d;
         grant_q  <= grant_d;
         dest_q   <= dest_d;
         len_q    <= len_d;
         remain_q <= remain_d;
         gap_q    <= gap_d;
      end
   end

endmodule

// File: tb/tb_ethernet_tx_scheduler.sv
// Self-checking bench for ethernet_tx_scheduler: expected MAC events queued at request time, checked by a monitor.
// Latency: n/a.
// Backpressure: a behavioural MAC reads bytes continuously; requester sources can be stalled via data_valid_i.
module tb_ethernet_tx_scheduler;

   localparam int IFG  = 8;
   localparam int MAXL = 1500;
   localparam logic [1:0] EV_TX   = 2'd0;
   localparam logic [1:0] EV_BYTE = 2'd1;
   localparam logic [1:0] EV_DONE = 2'd2;
   localparam logic [1:0] EV_REJ  = 2'd3;
   localparam logic [7:0] SEED0   = 8'h10;
   localparam logic [7:0] SEED1   = 8'hA0;

   typedef struct packed {
      logic [1:0]  kind;
      logic [63:0] val;
   } ev_t;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic [1:0]       request_i;
   logic [1:0][47:0] dest_address_i;
   logic [1:0][15:0] length_i;
   logic [1:0][7:0]  data_i;
   logic [1:0]       data_valid_i;
   logic [1:0]       data_read_o;
   logic [1:0]       grant_o;
   logic [1:0]       done_o;
   logic [1:0]       reject_o;
   logic             mac_transmit_o;
   logic [47:0]      mac_dest_address_o;
   logic [15:0]      mac_payload_length_o;
   logic             mac_read_descriptor_i;
   logic             mac_read_data_i;
   logic             mac_data_ready_o;
   logic [7:0]       mac_payload_data_o;
   logic             mac_tx_idle_i;

   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] pop_cnt [2] = '{16'd0, 16'd0};
   logic [15:0] base;
   logic [15:0] snap;
   int          n;
   int          g;

   int          m_phase = 0;
   int          m_left  = 0;
   int          m_tail  = 0;
   logic        m_fire;
   logic        m_tx;
   logic [15:0] m_len;

   ethernet_tx_scheduler #(.IFG_CYCLES(IFG), .MAX_LENGTH(MAXL)) dut (
      .clk_i                 (clk_i),
      .rst_n_i               (rst_n_i),
      .request_i             (request_i),
      .dest_address_i        (dest_address_i),
      .length_i              (length_i),
      .data_i                (data_i),
      .data_valid_i          (data_valid_i),
      .data_read_o           (data_read_o),
      .grant_o               (grant_o),
      .done_o                (done_o),
      .reject_o              (reject_o),
      .mac_transmit_o        (mac_transmit_o),
      .mac_dest_address_o    (mac_dest_address_o),
      .mac_payload_length_o  (mac_payload_length_o),
      .mac_read_descriptor_i (mac_read_descriptor_i),
      .mac_read_data_i       (mac_read_data_i),
      .mac_data_ready_o      (mac_data_ready_o),
      .mac_payload_data_o    (mac_payload_data_o),
      .mac_tx_idle_i         (mac_tx_idle_i)
   );

   always #5 clk_i = ~clk_i;

   // Byte sources: each pop advances the requester's running byte pattern.
   assign data_i[0] = SEED0 + pop_cnt[0][7:0];
   assign data_i[1] = SEED1 + pop_cnt[1][7:0];

   always @(posedge clk_i) begin
      for (int r = 0; r < 2; r++) begin
         if (data_read_o[r]) pop_cnt[r] <= pop_cnt[r] + 16'd1;
      end
   end

   function automatic logic [1:0] oh(input int r);
      return (r == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [7:0] seed_of(input int r);
      return (r == 0) ? SEED0 : SEED1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input logic [63:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int r, input logic [47:0] dest, input logic [15:0] len, input bit ok);
      logic [15:0] b;
      b = pop_cnt[r];
      dest_address_i[r] = dest;
      length_i[r]       = len;
      request_i[r]      = 1'b1;
      if (ok) begin
         push_ev(EV_TX, {len, dest});
         for (int k = 0; k < int'(len); k++) begin
            push_ev(EV_BYTE, {54'd0, oh(r), 8'(seed_of(r) + b[7:0] + 8'(k))});
         end
         push_ev(EV_DONE, {62'd0, oh(r)});
      end else begin
         push_ev(EV_REJ, {62'd0, oh(r)});
      end
   endtask

   // Waits for the end of requester r's transaction, then withdraws its request.
   task automatic wait_end(input int r);
      int c;
      c = 0;
      do begin
         @(negedge clk_i);
         c++;
      end while (!(done_o[r] || reject_o[r]) && c < 3000);
      chk($sformatf("end_of_req%0d", r), 64'(done_o[r] | reject_o[r]), 64'd1);
      @(posedge clk_i); #1;
      request_i[r] = 1'b0;
   endtask

   task automatic wait_pops(input int r, input logic [15:0] b, input int nmin, input string tag);
      int c;
      c = 0;
      while (int'(pop_cnt[r] - b) < nmin && c < 500) begin
         @(negedge clk_i);
         c++;
      end
      chk(tag, (int'(pop_cnt[r] - b) >= nmin) ? 64'd1 : 64'd0, 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({grant_o, done_o, reject_o, data_read_o, mac_transmit_o, mac_data_ready_o}), 64'd0);
      chk({tag, "_dest"}, 64'(mac_dest_address_o), 64'd0);
      chk({tag, "_len"},  64'(mac_payload_length_o), 64'd0);
      chk({tag, "_data"}, 64'(mac_payload_data_o), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   task automatic sb_check(input logic [1:0] kind, input logic [63:0] val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got kind %0d val %0h, expected no event", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.val !== val) begin
            errors++;
            $display("FAIL sb_event: got kind %0d val %0h, expected kind %0d val %0h", kind, val, e.kind, e.val);
         end
      end
   endtask

   // Monitor: every DUT-visible event is matched against the head of the expectation queue.
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (mac_transmit_o) sb_check(EV_TX, {mac_payload_length_o, mac_dest_address_o});
         if (mac_data_ready_o && mac_read_data_i) sb_check(EV_BYTE, {54'd0, data_read_o, mac_payload_data_o});
         if (done_o != 2'b00) sb_check(EV_DONE, {62'd0, done_o});
         if (reject_o != 2'b00) sb_check(EV_REJ, {62'd0, reject_o});
      end
   end

   // Behavioural MAC: latch descriptor a cycle after the start pulse, read bytes back to back, idle 2 cycles later.
   initial begin
      mac_tx_idle_i         = 1'b1;
      mac_read_descriptor_i = 1'b0;
      mac_read_data_i       = 1'b0;
      forever begin
         @(negedge clk_i);
         m_fire = mac_read_data_i & mac_data_ready_o;
         m_tx   = mac_transmit_o;
         m_len  = mac_payload_length_o;
         @(posedge clk_i); #1;
         if (!rst_n_i) begin
            m_phase               = 0;
            mac_tx_idle_i         = 1'b1;
            mac_read_descriptor_i = 1'b0;
            mac_read_data_i       = 1'b0;
         end else begin
            case (m_phase)
               0: if (m_tx) begin
                  mac_tx_idle_i = 1'b0;
                  m_left        = int'(m_len);
                  m_phase       = 1;
               end
               1: begin
                  mac_read_descriptor_i = 1'b1;
                  m_phase               = 2;
               end
               2: begin
                  mac_read_descriptor_i = 1'b0;
                  mac_read_data_i       = 1'b1;
                  m_phase               = 3;
               end
               3: begin
                  if (m_fire) m_left--;
                  if (m_left <= 0) begin
                     mac_read_data_i = 1'b0;
                     m_tail          = 2;
                     m_phase         = 4;
                  end
               end
               default: begin
                  if (m_tail == 0) begin
                     mac_tx_idle_i = 1'b1;
                     m_phase       = 0;
                  end else begin
                     m_tail--;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      request_i      = 2'b00;
      dest_address_i = '0;
      length_i       = '0;
      data_valid_i   = 2'b11;
      rst_n_i        = 1'b0;
      repeat (3) @(negedge clk_i);
      check_all_zero("reset");
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;

      // Single frame, requester 0, length 4: grant lasts IFG cycles past done.
      @(posedge clk_i); #1;
      base = pop_cnt[0];
      issue(0, 48'h0A0B0C0D0E0F, 16'd4, 1'b1);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (done_o[0] !== 1'b1 && n < 500);
      chk("t1_done", 64'(done_o[0]), 64'd1);
      chk("t1_grant_at_done", 64'(grant_o), 64'd1);
      chk("t1_pops", 64'(pop_cnt[0] - base), 64'd4);
      @(posedge clk_i); #1;
      request_i[0] = 1'b0;
      g = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (grant_o == 2'b01) g++;
         else break;
      end
      chk("t1_gap_cycles", 64'(g), 64'(IFG));

      // Simultaneous requests after reset: 0, then 1, then a second frame from 0.
      do_reset();
      @(posedge clk_i); #1;
      issue(0, 48'h001122334455, 16'd3, 1'b1);
      issue(1, 48'h66778899AABB, 16'd5, 1'b1);
      repeat (3) @(negedge clk_i);
      chk("t2_first_grant", 64'(grant_o), 64'd1);
      chk("t2_start_pulse", 64'(mac_transmit_o), 64'd1);
      wait_end(0);
      issue(0, 48'hCAFE00000001, 16'd2, 1'b1);
      wait_end(1);
      wait_end(0);

      // Rejects for requester 1 (length 0, then 1501); priority then favours 0.
      issue(1, 48'h0000000000AA, 16'd0, 1'b0);
      wait_end(1);
      chk("t3_no_grant", 64'(grant_o), 64'd0);
      issue(1, 48'h0000000000BB, 16'd1501, 1'b0);
      wait_end(1);
      issue(0, 48'h0000000000CC, 16'd2, 1'b1);
      issue(1, 48'h0000000000DD, 16'd3, 1'b1);
      wait_end(0);
      wait_end(1);

      // Source stall of 5 cycles mid-frame, length 8.
      base = pop_cnt[0];
      issue(0, 48'h123456789ABC, 16'd8, 1'b1);
      wait_pops(0, base, 3, "t4_pre_stall");
      @(posedge clk_i); #1;
      data_valid_i[0] = 1'b0;
      snap = pop_cnt[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("t4_stall_ready", 64'(mac_data_ready_o), 64'd0);
         chk("t4_stall_read", 64'(data_read_o), 64'd0);
      end
      chk("t4_stall_hold", 64'(pop_cnt[0]), 64'(snap));
      @(posedge clk_i); #1;
      data_valid_i[0] = 1'b1;
      wait_end(0);
      chk("t4_total_pops", 64'(pop_cnt[0] - base), 64'd8);

      // Reset while streaming: outputs clear, the aborted frame never completes.
      base = pop_cnt[0];
      issue(0, 48'h0F0E0D0C0B0A, 16'd10, 1'b1);
      wait_pops(0, base, 2, "t5_pre_reset");
      @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check_all_zero("t5_reset");
      exp_q.delete();
      request_i[0] = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      issue(0, 48'h0A0A0A0A0A0A, 16'd3, 1'b1);
      wait_end(0);

      // Request dropped and length changed while the MAC is latching the descriptor.
      base = pop_cnt[0];
      issue(0, 48'h112233445566, 16'd6, 1'b1);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (mac_transmit_o !== 1'b1 && n < 500);
      chk("t6_start_seen", 64'(mac_transmit_o), 64'd1);
      @(posedge clk_i); #1;
      request_i[0]      = 1'b0;
      length_i[0]       = 16'd2;
      dest_address_i[0] = 48'hFFFFFFFFFFFF;
      repeat (3) @(negedge clk_i);
      chk("t6_len_held", 64'(mac_payload_length_o), 64'd6);
      chk("t6_dest_held", 64'(mac_dest_address_o), 64'h112233445566);
      wait_end(0);
      chk("t6_total_pops", 64'(pop_cnt[0] - base), 64'd6);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      repeat (IFG + 4) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
